// File: rtl/ram_io_if.sv
// Bus bundle between the execute stage and the data-memory / I/O unit.
interface ram_io_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic              RD_EN;
  logic              WR_EN;
  logic [ADDR_W-1:0] RAM_AD_IN;
  logic [ADDR_W-1:0] WR_AD;
  logic [DATA_W-1:0] WR_DATA;
  logic [DATA_W-1:0] IO_IN;
  logic              IO_IN_STB;
  logic [ADDR_W-1:0] RAM_AD_OUT;
  logic [DATA_W-1:0] RAM_OUT;
  logic              RD_VALID;
  logic              ADDR_ERR;
  logic              IO_IN_FULL;
  logic              IO_IN_OVR;
  logic [DATA_W-1:0] IO_OUT;
  logic              IO_OUT_STB;

  modport master (
    output RD_EN, WR_EN, RAM_AD_IN, WR_AD, WR_DATA, IO_IN, IO_IN_STB,
    input  RAM_AD_OUT, RAM_OUT, RD_VALID, ADDR_ERR, IO_IN_FULL, IO_IN_OVR,
           IO_OUT, IO_OUT_STB
  );

  modport slave (
    input  RD_EN, WR_EN, RAM_AD_IN, WR_AD, WR_DATA, IO_IN, IO_IN_STB,
    output RAM_AD_OUT, RAM_OUT, RD_VALID, ADDR_ERR, IO_IN_FULL, IO_IN_OVR,
           IO_OUT, IO_OUT_STB
  );
endinterface

// File: rtl/ram_io_unit.sv
// Registered data RAM with one latched input port and one strobed output
// port sharing the address space. One read and one write per cycle, reads
// see state from before the edge (read-before-write everywhere).
module ram_io_unit #(
  parameter int                 DATA_W    = 16,
  parameter int                 ADDR_W    = 8,
  parameter int                 DEPTH     = 8,
  parameter logic [ADDR_W-1:0]  IO_IN_AD  = 8'h41,
  parameter logic [ADDR_W-1:0]  IO_OUT_AD = 8'h40
) (
  input  logic     CLK_DC,
  input  logic     RESET_N,
  ram_io_if.slave  bus
);
  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_W = DEPTH[ADDR_W:0];

  logic [DATA_W-1:0] ram [DEPTH];
  logic [DATA_W-1:0] latch;

  logic              rd_ram, rd_in, rd_out, rd_err;
  logic              wr_ram, wr_out, wr_err;
  logic [DATA_W-1:0] rd_data;
  logic [IDX_W-1:0]  rd_idx, wr_idx;

  assign rd_idx = bus.RAM_AD_IN[IDX_W-1:0];
  assign wr_idx = bus.WR_AD[IDX_W-1:0];

  // Address decode; full-width compares so nothing aliases.
  always_comb begin
    rd_ram = bus.RD_EN && ({1'b0, bus.RAM_AD_IN} < DEPTH_W);
    rd_in  = bus.RD_EN && (bus.RAM_AD_IN == IO_IN_AD);
    rd_out = bus.RD_EN && (bus.RAM_AD_IN == IO_OUT_AD);
    rd_err = bus.RD_EN && !(rd_ram || rd_in || rd_out);
    wr_ram = bus.WR_EN && ({1'b0, bus.WR_AD} < DEPTH_W);
    wr_out = bus.WR_EN && (bus.WR_AD == IO_OUT_AD);
    wr_err = bus.WR_EN && !(wr_ram || wr_out);
  end

  // Read data mux; unmapped addresses return zero.
  always_comb begin
    rd_data = '0;
    if (rd_ram)      rd_data = ram[rd_idx];
    else if (rd_in)  rd_data = latch;
    else if (rd_out) rd_data = bus.IO_OUT;
  end

  // RAM array: cleared on reset, written from the execute stage.
  always_ff @(posedge CLK_DC or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
    end else if (wr_ram) begin
      ram[wr_idx] <= bus.WR_DATA;
    end
  end

  // Read result registers, valid/error pulses and output port.
  always_ff @(posedge CLK_DC or negedge RESET_N) begin
    if (!RESET_N) begin
      bus.RAM_OUT    <= '0;
      bus.RAM_AD_OUT <= '0;
      bus.RD_VALID   <= 1'b0;
      bus.ADDR_ERR   <= 1'b0;
      bus.IO_OUT     <= '0;
      bus.IO_OUT_STB <= 1'b0;
    end else begin
      bus.RD_VALID   <= bus.RD_EN;
      bus.ADDR_ERR   <= rd_err | wr_err;
      bus.IO_OUT_STB <= wr_out;
      if (bus.RD_EN) begin
        bus.RAM_OUT    <= rd_data;
        bus.RAM_AD_OUT <= bus.RAM_AD_IN;
      end
      if (wr_out) bus.IO_OUT <= bus.WR_DATA;
    end
  end

  // Input latch: a strobe always wins over a same-cycle drain, and only a
  // strobe into an undrained latch counts as an overrun.
  always_ff @(posedge CLK_DC or negedge RESET_N) begin
    if (!RESET_N) begin
      latch          <= '0;
      bus.IO_IN_FULL <= 1'b0;
      bus.IO_IN_OVR  <= 1'b0;
    end else if (bus.IO_IN_STB) begin
      latch          <= bus.IO_IN;
      bus.IO_IN_FULL <= 1'b1;
      if (bus.IO_IN_FULL && !rd_in) bus.IO_IN_OVR <= 1'b1;
    end else if (rd_in) begin
      bus.IO_IN_FULL <= 1'b0;
    end
  end
endmodule
